// File: rtl/ram_sched_pkg.sv
// Shared types and helpers for the maze-level RAM scheduler.
package ram_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SERVE = 2'd2
  } state_t;

  localparam logic [0:0] REQ_CGR = 1'b0;
  localparam logic [0:0] REQ_SQG = 1'b1;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2
  import ram_sched_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q;

  always_comb begin
    gnt = 2'b00;
    if (req[REQ_CGR] && (!req[REQ_SQG] || (last_q == REQ_SQG))) begin
      gnt[REQ_CGR] = 1'b1;
    end else if (req[REQ_SQG]) begin
      gnt[REQ_SQG] = 1'b1;
    end
  end

  // Reset to "sqg last" so cgr wins the first tie.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q <= REQ_SQG;
    end else if (|gnt) begin
      last_q <= gnt[REQ_SQG];
    end
  end

endmodule

// File: rtl/ram_sched.sv
// Maze-level RAM scheduler: clear sweep, round-robin write port, backtrace reads.
// Optional write-to-read bypass enabled by defining RAM_SCHED_FWD_EN.
module ram_sched
  import ram_sched_pkg::*;
#(
  parameter int unsigned ADDR_LEN = 6,
  parameter int unsigned DATA_LEN = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start_clr,
  output logic                clr_busy,
  output logic                clr_done,
  input  logic                cgr_req,
  input  logic [ADDR_LEN:0]   cgr_addr,
  input  logic [DATA_LEN-1:0] cgr_data,
  output logic                cgr_gnt,
  input  logic                sqg_req,
  input  logic [ADDR_LEN:0]   sqg_addr,
  input  logic [DATA_LEN-1:0] sqg_data,
  output logic                sqg_gnt,
  input  logic                bc_req,
  input  logic [ADDR_LEN:0]   bc_addr,
  output logic                bc_gnt,
  output logic                bc_rd_valid,
  output logic [DATA_LEN-1:0] bc_rd_data,
  output logic                ram_wr_en,
  output logic [ADDR_LEN:0]   ram_wr_addr,
  output logic [DATA_LEN-1:0] ram_wr_data,
  output logic [ADDR_LEN:0]   ram_rd_addr,
  input  logic [DATA_LEN-1:0] ram_rd_data
);

  localparam int unsigned AW    = ADDR_LEN + 1;
  localparam int unsigned DEPTH = depth_of(AW);
  localparam int unsigned CW    = AW + 1;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                clr_last;
  logic [1:0]          arb_req, arb_gnt;
  logic                busy_d, done_d, wr_en_d, rd_valid_d;
  logic [ADDR_LEN:0]   wr_addr_d, rd_addr_d;
  logic [DATA_LEN-1:0] wr_data_d;

  assign clr_last = (cnt_q == CW'(DEPTH - 1));

  // State and sweep counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_clr) state_d = CLEAR;
      CLEAR:   if (clr_last)  state_d = SERVE;
      SERVE:   if (start_clr) state_d = CLEAR;
      default: state_d = IDLE;
    endcase
  end

  // Writers only compete in SERVE, and not in the cycle a new sweep is launched.
  always_comb begin
    arb_req          = 2'b00;
    arb_req[REQ_CGR] = (state_q == SERVE) && !start_clr && cgr_req;
    arb_req[REQ_SQG] = (state_q == SERVE) && !start_clr && sqg_req;
  end

  rr_arb2 u_arb (
    .CLK (CLK),
    .RST (RST),
    .req (arb_req),
    .gnt (arb_gnt)
  );

  // Grants and next values of the registered outputs; clear writes are
  // pre-computed so ram_wr_* line up with clr_busy.
  always_comb begin
    cnt_d      = '0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    wr_en_d    = 1'b0;
    wr_addr_d  = ram_wr_addr;
    wr_data_d  = ram_wr_data;
    rd_addr_d  = ram_rd_addr;
    rd_valid_d = 1'b0;
    cgr_gnt    = 1'b0;
    sqg_gnt    = 1'b0;
    bc_gnt     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_clr) begin
          busy_d    = 1'b1;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = '0;
        end
      end
      CLEAR: begin
        if (clr_last) begin
          done_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + CW'(1);
          busy_d    = 1'b1;
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_d[AW-1:0];
          wr_data_d = '0;
        end
      end
      SERVE: begin
        bc_gnt     = bc_req;
        rd_valid_d = bc_req;
        if (bc_req) rd_addr_d = bc_addr;
        if (start_clr) begin
          busy_d    = 1'b1;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = '0;
        end else begin
          cgr_gnt = arb_gnt[REQ_CGR];
          sqg_gnt = arb_gnt[REQ_SQG];
          if (arb_gnt[REQ_CGR]) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cgr_addr;
            wr_data_d = cgr_data;
          end else if (arb_gnt[REQ_SQG]) begin
            wr_en_d   = 1'b1;
            wr_addr_d = sqg_addr;
            wr_data_d = sqg_data;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      clr_busy    <= 1'b0;
      clr_done    <= 1'b0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      ram_rd_addr <= '0;
      bc_rd_valid <= 1'b0;
    end else begin
      clr_busy    <= busy_d;
      clr_done    <= done_d;
      ram_wr_en   <= wr_en_d;
      ram_wr_addr <= wr_addr_d;
      ram_wr_data <= wr_data_d;
      ram_rd_addr <= rd_addr_d;
      bc_rd_valid <= rd_valid_d;
    end
  end

  // RAM read is asynchronous, so data is passed through in the valid cycle.
  always_comb begin
    bc_rd_data = '0;
    if (bc_rd_valid) begin
`ifdef RAM_SCHED_FWD_EN
      bc_rd_data = (ram_wr_en && (ram_wr_addr == ram_rd_addr)) ? ram_wr_data : ram_rd_data;
`else
      bc_rd_data = ram_rd_data;
`endif
    end
  end

endmodule

// File: tb/tb_ram_sched.sv
// Bench for ram_sched: directed scenarios plus a randomized serve phase against a RAM model.
module tb_ram_sched;

  localparam int unsigned ADDR_LEN = 2;
  localparam int unsigned DATA_LEN = 8;
  localparam int unsigned DEPTH    = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start_clr = 1'b0;
  logic       clr_busy, clr_done;
  logic       cgr_req = 1'b0, sqg_req = 1'b0, bc_req = 1'b0;
  logic [2:0] cgr_addr = '0, sqg_addr = '0, bc_addr = '0;
  logic [7:0] cgr_data = '0, sqg_data = '0;
  logic       cgr_gnt, sqg_gnt, bc_gnt, bc_rd_valid, ram_wr_en;
  logic [7:0] bc_rd_data, ram_wr_data, ram_rd_data;
  logic [2:0] ram_wr_addr, ram_rd_addr;

  ram_sched #(.ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN)) dut (
    .CLK(CLK), .RST(RST), .start_clr(start_clr), .clr_busy(clr_busy), .clr_done(clr_done),
    .cgr_req(cgr_req), .cgr_addr(cgr_addr), .cgr_data(cgr_data), .cgr_gnt(cgr_gnt),
    .sqg_req(sqg_req), .sqg_addr(sqg_addr), .sqg_data(sqg_data), .sqg_gnt(sqg_gnt),
    .bc_req(bc_req), .bc_addr(bc_addr), .bc_gnt(bc_gnt), .bc_rd_valid(bc_rd_valid),
    .bc_rd_data(bc_rd_data), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  always #5 CLK = ~CLK;

  // The RAM itself: synchronous write, asynchronous read.
  logic [7:0] ram [DEPTH];
  always @(posedge CLK) if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
  assign ram_rd_data = ram[ram_rd_addr];

  int checks = 0;
  int failures = 0;

  // Reference state: expected RAM contents and which writer won most recently.
  logic [7:0] model_mem [DEPTH];
  logic       last_sqg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [1:0] exp_gnt(input logic c, input logic s, input logic sqg_was_last);
    if (c && s) return sqg_was_last ? 2'b01 : 2'b10;
    return {s, c};
  endfunction

  task automatic model_reset();
    last_sqg = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 8'h00;
  endtask

  // One SERVE cycle: check grants, clock, check write port and read return.
  task automatic serve_cycle(input string tag, output logic [1:0] g);
    logic [2:0] wa, ra;
    logic [7:0] wd, er;
    logic       rv;
    #1;
    g = exp_gnt(cgr_req, sqg_req, last_sqg);
    chk({tag, ".cgr_gnt"}, 32'(cgr_gnt), 32'(g[0]));
    chk({tag, ".sqg_gnt"}, 32'(sqg_gnt), 32'(g[1]));
    chk({tag, ".bc_gnt"}, 32'(bc_gnt), 32'(bc_req));
    wa = g[1] ? sqg_addr : cgr_addr;
    wd = g[1] ? sqg_data : cgr_data;
    if (g != 2'b00) last_sqg = g[1];
    ra = bc_addr;
    rv = bc_req;
    tick();
    chk({tag, ".wr_en"}, 32'(ram_wr_en), 32'(g != 2'b00));
    if (g != 2'b00) begin
      chk({tag, ".wr_addr"}, 32'(ram_wr_addr), 32'(wa));
      chk({tag, ".wr_data"}, 32'(ram_wr_data), 32'(wd));
    end
    chk({tag, ".rd_valid"}, 32'(bc_rd_valid), 32'(rv));
    if (rv) begin
      er = model_mem[ra];
`ifdef RAM_SCHED_FWD_EN
      if (g != 2'b00 && wa == ra) er = wd;
`endif
      chk({tag, ".rd_addr"}, 32'(ram_rd_addr), 32'(ra));
      chk({tag, ".rd_data"}, 32'(bc_rd_data), 32'(er));
    end
    if (g != 2'b00) model_mem[wa] = wd;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, ".clr_busy"}, 32'(clr_busy), 32'd0);
    chk({tag, ".clr_done"}, 32'(clr_done), 32'd0);
    chk({tag, ".wr_en"}, 32'(ram_wr_en), 32'd0);
    chk({tag, ".wr_addr"}, 32'(ram_wr_addr), 32'd0);
    chk({tag, ".rd_valid"}, 32'(bc_rd_valid), 32'd0);
    chk({tag, ".grants"}, 32'({cgr_gnt, sqg_gnt, bc_gnt}), 32'd0);
  endtask

  // Full sweep from the cycle after start_clr is sampled through clr_done.
  task automatic sweep(input string tag, input int unsigned first);
    for (int i = int'(first); i < int'(DEPTH); i++) begin
      chk({tag, ".busy"}, 32'(clr_busy), 32'd1);
      chk({tag, ".wr_en"}, 32'(ram_wr_en), 32'd1);
      chk({tag, ".wr_addr"}, 32'(ram_wr_addr), 32'(i));
      chk({tag, ".wr_data"}, 32'(ram_wr_data), 32'd0);
      chk({tag, ".done"}, 32'(clr_done), 32'd0);
      chk({tag, ".grants"}, 32'({cgr_gnt, sqg_gnt, bc_gnt}), 32'd0);
      start_clr = (i == 3);
      if (i == int'(DEPTH) - 1) begin
        cgr_req = 1'b0; sqg_req = 1'b0; bc_req = 1'b0;
      end
      tick();
    end
    chk({tag, ".done_pulse"}, 32'(clr_done), 32'd1);
    chk({tag, ".busy_end"}, 32'(clr_busy), 32'd0);
    chk({tag, ".wr_en_end"}, 32'(ram_wr_en), 32'd0);
    tick();
    chk({tag, ".done_once"}, 32'(clr_done), 32'd0);
    model_reset();
  endtask

  initial begin
    logic [1:0] g;
    model_reset();

    // Reset state, then no grants in IDLE even with every request up.
    repeat (3) tick();
    check_idle_outputs("reset");
    chk("reset.rd_data", 32'(bc_rd_data), 32'd0);
    RST = 1'b0;
    cgr_req = 1'b1; sqg_req = 1'b1; bc_req = 1'b1; bc_addr = 3'd2;
    #1;
    chk("idle.grants", 32'({cgr_gnt, sqg_gnt, bc_gnt}), 32'd0);
    tick();
    check_idle_outputs("idle");

    // Clear sweep with requests pending and a start_clr retrigger mid-sweep.
    start_clr = 1'b1;
    #1;
    chk("clr_start.grants", 32'({cgr_gnt, sqg_gnt, bc_gnt}), 32'd0);
    tick();
    start_clr = 1'b0;
    sweep("clear", 0);

    // Lone sqg request; the following tie must then go to cgr.
    sqg_req = 1'b1; sqg_addr = 3'd5; sqg_data = 8'h23;
    serve_cycle("single", g);
    chk("single.wr_addr5", 32'(ram_wr_addr), 32'd5);
    chk("single.wr_data23", 32'(ram_wr_data), 32'h23);

    // Both writers every cycle: strict alternation starting with cgr.
    cgr_req = 1'b1; sqg_req = 1'b1;
    cgr_addr = 3'($urandom); cgr_data = 8'($urandom);
    sqg_addr = 3'($urandom); sqg_data = 8'($urandom);
    for (int k = 0; k < 6; k++) begin
      serve_cycle("rr", g);
      chk("rr.order", 32'(g), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (g[0]) begin cgr_addr = 3'($urandom); cgr_data = 8'($urandom); end
      if (g[1]) begin sqg_addr = 3'($urandom); sqg_data = 8'($urandom); end
    end
    sqg_req = 1'b0;

    // Read back a known value, then confirm the read address holds when idle.
    cgr_addr = 3'd3; cgr_data = 8'h07;
    serve_cycle("wr3", g);
    cgr_req = 1'b0;
    bc_req = 1'b1; bc_addr = 3'd3;
    serve_cycle("read", g);
    chk("read.data07", 32'(bc_rd_data), 32'h07);
    bc_req = 1'b0; bc_addr = 3'd6;
    serve_cycle("rd_idle", g);
    chk("rd_idle.hold", 32'(ram_rd_addr), 32'd3);

    // Same-address write and read in one cycle.
    cgr_req = 1'b1; cgr_addr = 3'd3; cgr_data = 8'h11;
    bc_req = 1'b1; bc_addr = 3'd3;
    serve_cycle("collide", g);
`ifdef RAM_SCHED_FWD_EN
    chk("collide.fwd", 32'(bc_rd_data), 32'h11);
`else
    chk("collide.old", 32'(bc_rd_data), 32'h07);
`endif
    cgr_req = 1'b0; bc_req = 1'b0;

    // Randomized traffic; a writer keeps its request and payload until granted.
    for (int k = 0; k < 120; k++) begin
      if (!cgr_req) begin
        cgr_req = 1'($urandom); cgr_addr = 3'($urandom); cgr_data = 8'($urandom);
      end
      if (!sqg_req) begin
        sqg_req = 1'($urandom); sqg_addr = 3'($urandom); sqg_data = 8'($urandom);
      end
      bc_req = 1'($urandom); bc_addr = 3'($urandom);
      serve_cycle("rand", g);
      if (g[0]) cgr_req = 1'b0;
      if (g[1]) sqg_req = 1'b0;
    end
    bc_req = 1'b0; sqg_req = 1'b0;

    // Reset during SERVE drops the write granted in that cycle.
    cgr_req = 1'b1; cgr_addr = 3'd1; cgr_data = 8'h5a;
    RST = 1'b1;
    tick();
    check_idle_outputs("rst_serve");
    RST = 1'b0;
    tick();
    chk("rst_serve.idle_gnt", 32'(cgr_gnt), 32'd0);
    cgr_req = 1'b0;
    model_reset();

    // Reset at sweep address 4, then a fresh sweep restarts from 0.
    start_clr = 1'b1;
    tick();
    start_clr = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      chk("mid.wr_addr", 32'(ram_wr_addr), 32'(i));
      if (i < 4) tick();
    end
    RST = 1'b1;
    tick();
    check_idle_outputs("mid_rst");
    RST = 1'b0;
    start_clr = 1'b1;
    tick();
    start_clr = 1'b0;
    sweep("reclear", 0);

    // Arbiter pointer was reset: first tie goes to cgr.
    cgr_req = 1'b1; sqg_req = 1'b1;
    cgr_addr = 3'd6; cgr_data = 8'hc3; sqg_addr = 3'd7; sqg_data = 8'h3c;
    serve_cycle("post_rst_tie", g);
    chk("post_rst_tie.cgr", 32'(g), 32'd1);
    cgr_req = 1'b0; sqg_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
